// File: rtl/flash_writer_pkg.sv
// Shared constants and types for the flash program/erase writer.
package flash_writer_pkg;

    // Flash command words
    localparam logic [15:0] CMD_PROGRAM    = 16'h0040;
    localparam logic [15:0] CMD_ERASE      = 16'h0020;
    localparam logic [15:0] CMD_CONFIRM    = 16'h00D0;
    localparam logic [15:0] CMD_CLR_SR     = 16'h0050;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    // Status register bit positions
    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPP_ERR   = 3;
    localparam int SR_LOCK_ERR  = 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD1, ST_CMD2, ST_POLL, ST_CLR, ST_RESTORE, ST_FIN
    } state_e;

    typedef enum logic [2:0] {
        BP_IDLE, BP_SETUP, BP_PULSE, BP_HOLD, BP_RLOW, BP_RREC
    } bus_phase_e;

    // Any failure bit reported by the device once it is ready
    function automatic logic sr_has_error(input logic [7:0] sr);
        return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Timed single flash bus cycle: 3-phase write or P-clock read plus 1 recovery clock.
// A new start may be accepted on the same edge the previous cycle finishes.
module flash_bus_cycle
    import flash_writer_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_read,
    input  logic [15:0] wdata,
    output logic        ce,
    output logic        oe,
    output logic        we,
    output logic        drive,
    output logic [15:0] dout,
    output logic        cyc_done,
    output logic        sample
);

    localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

    bus_phase_e phase;
    logic [3:0] cnt;
    logic       last;

    assign last     = (cnt == LAST);
    assign cyc_done = (phase == BP_HOLD && last) || (phase == BP_RREC);
    assign sample   = (phase == BP_RLOW && last);

    // Phase sequencer; strobes are registered so reset returns them high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= BP_IDLE;
            cnt   <= '0;
            ce    <= 1'b1;
            oe    <= 1'b1;
            we    <= 1'b1;
            drive <= 1'b0;
            dout  <= '0;
        end else if (start) begin
            phase <= is_read ? BP_RLOW : BP_SETUP;
            cnt   <= '0;
            ce    <= 1'b0;
            oe    <= is_read ? 1'b0 : 1'b1;
            we    <= 1'b1;
            drive <= ~is_read;
            dout  <= wdata;
        end else begin
            cnt <= last ? 4'd0 : cnt + 4'd1;
            case (phase)
                BP_IDLE:  cnt <= '0;
                BP_SETUP: if (last) begin phase <= BP_PULSE; we <= 1'b0; end
                BP_PULSE: if (last) begin phase <= BP_HOLD; we <= 1'b1; ce <= 1'b1; end
                BP_HOLD:  if (last) begin phase <= BP_IDLE; drive <= 1'b0; end
                BP_RLOW:  if (last) begin phase <= BP_RREC; ce <= 1'b1; oe <= 1'b1; end
                BP_RREC:  begin phase <= BP_IDLE; cnt <= '0; end
                default:  phase <= BP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/flash_writer.sv
// Word program / block erase controller for a parallel NOR flash.
// Sequences command writes, status polling, error clear and return to read-array.
module flash_writer
    import flash_writer_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter logic [23:0] POLL_LIMIT   = 24'd8_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_req,
    input  logic        erase_req,
    input  logic [21:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status_out,
    output logic [22:0] flash_addr,
    inout  wire  [15:0] flash_data,
    output logic        flash_byte,
    output logic        flash_vpen,
    output logic        flash_rp,
    output logic        flash_ce,
    output logic        flash_oe,
    output logic        flash_we
);

    state_e      state, nstate;
    logic        op_erase;
    logic [15:0] wdata_q;
    logic [23:0] poll_cnt;
    logic        start, is_read, cyc_done, sample, bus_drive;
    logic [15:0] cmd, bus_dout;
    logic        sr_ready, poll_timeout;

    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_rp   = 1'b1;
    assign flash_data = bus_drive ? bus_dout : 16'hzzzz;

    assign sr_ready     = status_out[SR_READY];
    assign poll_timeout = (poll_cnt + 24'd1) >= POLL_LIMIT;

    flash_bus_cycle #(.PHASE_CYCLES(PHASE_CYCLES)) u_bus (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_read  (is_read),
        .wdata    (cmd),
        .ce       (flash_ce),
        .oe       (flash_oe),
        .we       (flash_we),
        .drive    (bus_drive),
        .dout     (bus_dout),
        .cyc_done (cyc_done),
        .sample   (sample)
    );

    // Next state and the bus cycle to launch, issued on the edge the previous one ends
    always_comb begin
        nstate  = state;
        start   = 1'b0;
        is_read = 1'b0;
        cmd     = CMD_READ_ARRAY;
        case (state)
            ST_IDLE: if (prog_req || erase_req) begin
                start  = 1'b1;
                nstate = ST_CMD1;
                cmd    = prog_req ? CMD_PROGRAM : CMD_ERASE;
            end
            ST_CMD1: if (cyc_done) begin
                start  = 1'b1;
                nstate = ST_CMD2;
                cmd    = op_erase ? CMD_CONFIRM : wdata_q;
            end
            ST_CMD2: if (cyc_done) begin
                start   = 1'b1;
                is_read = 1'b1;
                nstate  = ST_POLL;
            end
            ST_POLL: if (cyc_done) begin
                start = 1'b1;
                if (sr_ready) begin
                    nstate = sr_has_error(status_out) ? ST_CLR : ST_RESTORE;
                    cmd    = sr_has_error(status_out) ? CMD_CLR_SR : CMD_READ_ARRAY;
                end else if (poll_timeout) begin
                    nstate = ST_CLR;
                    cmd    = CMD_CLR_SR;
                end else begin
                    is_read = 1'b1;
                end
            end
            ST_CLR: if (cyc_done) begin
                start  = 1'b1;
                nstate = ST_RESTORE;
            end
            ST_RESTORE: if (cyc_done) nstate = ST_FIN;
            ST_FIN:     nstate = ST_IDLE;
            default:    nstate = ST_IDLE;
        endcase
    end

    // Controller state, request latching, poll counting and host-visible outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_erase   <= 1'b0;
            wdata_q    <= '0;
            poll_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            status_out <= '0;
            flash_addr <= '0;
        end else begin
            state <= nstate;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    busy       <= 1'b1;
                    error      <= 1'b0;
                    poll_cnt   <= '0;
                    op_erase   <= ~prog_req;
                    wdata_q    <= wdata;
                    flash_addr <= {addr, 1'b0};
                end
                ST_POLL: if (cyc_done) begin
                    poll_cnt <= poll_cnt + 24'd1;
                    if (sr_ready ? sr_has_error(status_out) : poll_timeout)
                        error <= 1'b1;
                end
                ST_RESTORE: if (cyc_done) done <= 1'b1;
                ST_FIN:     busy <= 1'b0;
                default: ;
            endcase
            if (sample)
                status_out <= flash_data[7:0];
        end
    end

endmodule
